// File: rtl/pipe_stage.sv
// Pipeline register stage with valid/ready handshake, flush and a saturating stall counter.
// Latency: one cycle from accept to out_valid_o. Optional skid entry via PIPE_STAGE_SKID_EN.
// Backpressure: default ready is combinational (!out_valid_o || out_ready_i); skid build registers ready.
module pipe_stage #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    input  logic             flush_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic             main_vld;
    logic [WIDTH-1:0] main_dat;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall;
    logic             accept;
    logic             xfer;

    assign stall       = main_vld && !out_ready_i && !flush_i;
    assign xfer        = main_vld && out_ready_i && !flush_i;
    assign out_valid_o = main_vld;
    assign out_data_o  = main_dat;
    assign stall_cnt_o = stall_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_vld;
    logic [WIDTH-1:0] skid_dat;
    logic             rdy_q;
    logic             main_vld_nxt;
    logic             skid_vld_nxt;
    logic [WIDTH-1:0] main_dat_nxt;
    logic [WIDTH-1:0] skid_dat_nxt;

    assign in_ready_o = rdy_q;
    assign accept     = in_valid_i && rdy_q && !flush_i;

    // Ready is low whenever the skid entry holds a beat, so no accept can coincide with it.
    always_comb begin
        main_vld_nxt = main_vld;
        skid_vld_nxt = skid_vld;
        main_dat_nxt = main_dat;
        skid_dat_nxt = skid_dat;
        if (flush_i) begin
            main_vld_nxt = 1'b0;
            skid_vld_nxt = 1'b0;
        end else if (skid_vld) begin
            if (xfer) begin
                main_dat_nxt = skid_dat;
                skid_vld_nxt = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld || xfer) begin
                main_vld_nxt = 1'b1;
                main_dat_nxt = in_data_i;
            end else begin
                skid_vld_nxt = 1'b1;
                skid_dat_nxt = in_data_i;
            end
        end else if (xfer) begin
            main_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
            rdy_q    <= 1'b1;
        end else begin
            main_vld <= main_vld_nxt;
            skid_vld <= skid_vld_nxt;
            main_dat <= main_dat_nxt;
            skid_dat <= skid_dat_nxt;
            rdy_q    <= !skid_vld_nxt;
        end
    end
`else
    assign in_ready_o = !main_vld || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_vld <= 1'b0;
            main_dat <= '0;
        end else if (flush_i) begin
            main_vld <= 1'b0;
        end else if (accept) begin
            main_vld <= 1'b1;
            main_dat <= in_data_i;
        end else if (xfer) begin
            main_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: queue-based reference model plus directed and random stimulus.
module tb_pipe_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic [63:0] in_data_i;
    logic        flush_i;
    logic        out_ready_i;
    logic        in_ready_o,  in_ready_o4;
    logic        out_valid_o, out_valid_o4;
    logic [63:0] out_data_o,  out_data_o4;
    logic [15:0] stall_cnt_o;
    logic [3:0]  stall_cnt_o4;

    int tests = 0;
    int fails = 0;

    pipe_stage #(.WIDTH(64), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .out_valid_o(out_valid_o),
        .out_data_o(out_data_o), .out_ready_i(out_ready_i), .stall_cnt_o(stall_cnt_o)
    );

    pipe_stage #(.WIDTH(64), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_o4), .flush_i(flush_i), .out_valid_o(out_valid_o4),
        .out_data_o(out_data_o4), .out_ready_i(out_ready_i), .stall_cnt_o(stall_cnt_o4)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of accepted beats (capacity 1, or 2 with skid).
    logic [63:0] q[$];
    logic [63:0] last_data = '0;
    int          cnt16 = 0;
    int          cnt4  = 0;

    function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready_i;
`endif
    endfunction

    initial begin
        logic rdy;
        forever begin
            @(posedge clk_i);
            if (!rst_i) begin
                q.delete(); last_data = '0; cnt16 = 0; cnt4 = 0;
            end else if (flush_i) begin
                q.delete();
            end else begin
                rdy = model_ready();
                if (q.size() > 0 && !out_ready_i) begin
                    if (cnt16 < 65535) cnt16++;
                    if (cnt4 < 15) cnt4++;
                end
                if (q.size() > 0 && out_ready_i) void'(q.pop_front());
                if (in_valid_i && rdy) q.push_back(in_data_i);
            end
            if (q.size() > 0) last_data = q[0];
            @(negedge clk_i);
            if (!rst_i) begin
                q.delete(); last_data = '0; cnt16 = 0; cnt4 = 0;
                chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
                chk("rst_out_data", out_data_o, 64'd0);
                chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
                chk("rst_stall_cnt", {48'd0, stall_cnt_o}, 64'd0);
            end else begin
                chk("out_valid", {63'd0, out_valid_o}, {63'd0, q.size() != 0});
                chk("out_data", out_data_o, (q.size() != 0) ? q[0] : last_data);
                chk("in_ready", {63'd0, in_ready_o}, {63'd0, model_ready()});
                chk("stall_cnt", {48'd0, stall_cnt_o}, 64'(cnt16));
                chk("stall_cnt4", {60'd0, stall_cnt_o4}, 64'(cnt4));
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic f);
        in_valid_i = v; in_data_i = d; out_ready_i = r; flush_i = f;
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(0, 64'd0, 1, 0);
        repeat (2) step();
        chk("lit_reset_ready", {63'd0, in_ready_o}, 64'd1);
        chk("lit_reset_valid", {63'd0, out_valid_o}, 64'd0);
        rst_i = 1'b1;
        step();

        // Streaming 1..8 with no bubbles
        for (int i = 1; i <= 8; i++) begin
            drive(1, 64'(i), 1, 0);
            step();
            chk("lit_stream_valid", {63'd0, out_valid_o}, 64'd1);
            chk("lit_stream_data", out_data_o, 64'(i));
        end
        drive(0, 64'd0, 1, 0);
        step();
        chk("lit_stream_drain", {63'd0, out_valid_o}, 64'd0);
        chk("lit_stream_stall", {48'd0, stall_cnt_o}, 64'd0);

        // Hold 0xAA for 5 stalled edges
        drive(1, 64'hAA, 0, 0);
        step();
        drive(0, 64'd0, 0, 0);
        repeat (5) step();
        chk("lit_hold_data", out_data_o, 64'hAA);
        chk("lit_hold_stall", {48'd0, stall_cnt_o}, 64'd5);
        drive(0, 64'd0, 1, 0);
        step();
        chk("lit_hold_release", {63'd0, out_valid_o}, 64'd0);

        // Flush with 0x44 held and 0x55 offered
        drive(1, 64'h44, 0, 0);
        step();
        drive(1, 64'h55, 0, 1);
        step();
        chk("lit_flush_valid", {63'd0, out_valid_o}, 64'd0);
        chk("lit_flush_data_kept", out_data_o, 64'h44);
        drive(0, 64'd0, 1, 0);
        repeat (2) step();
        chk("lit_flush_after", {63'd0, out_valid_o}, 64'd0);

        // Saturation of the 4-bit counter over 20 stalled edges
        drive(1, 64'h33, 0, 0);
        step();
        drive(0, 64'd0, 0, 0);
        repeat (20) step();
        chk("lit_sat_cnt4", {60'd0, stall_cnt_o4}, 64'd15);
        chk("lit_sat_cnt16", {48'd0, stall_cnt_o}, 64'd25);
        drive(0, 64'd0, 1, 0);
        step();

        // Asynchronous reset with 0x77 held
        drive(1, 64'h77, 0, 0);
        step();
        drive(0, 64'd0, 0, 0);
        #1 rst_i = 1'b0;
        #1;
        chk("lit_arst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("lit_arst_data", out_data_o, 64'd0);
        step();
        rst_i = 1'b1;
        chk("lit_arst_ready", {63'd0, in_ready_o}, 64'd1);
        drive(0, 64'd0, 1, 0);
        step();
        chk("lit_arst_nobeat", {63'd0, out_valid_o}, 64'd0);

        // Random traffic checked against the queue model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0,
                  ($urandom % 40) == 0);
            step();
        end

`ifdef PIPE_STAGE_SKID_EN
        // Ready must not react to out_ready_i within a cycle
        drive(1, 64'h1234, 0, 0);
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            logic r0;
            out_ready_i = 1'b0;
            #1 r0 = in_ready_o;
            out_ready_i = 1'b1;
            #1 chk("ready_comb_indep", {63'd0, in_ready_o}, {63'd0, r0});
            out_ready_i = (i % 2) == 0;
            step();
        end
`endif

        drive(0, 64'd0, 1, 0);
        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
